// File: rtl/uart_cmd_master.sv
// Host-side initiator for the UART housekeeping command protocol: serializes
// "xxm" / "xxw" / "r" character sequences and captures the 1-byte read reply.
module uart_cmd_master #(
    parameter int ADDR_CACHE = 1,
    parameter int RX_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baudclk16,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic [2:0] dbg_state
);
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT_RX, S_RESP} state_t;

    // Handshake: a request transfers on a clk edge where req_valid & req_ready;
    // req_ready is high only in IDLE and drops from the accept edge through RESP.
    state_t        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          tx_q, tx_d;
    logic          wr_q, wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          cache_valid_q, cache_valid_d;
    logic [7:0]    cache_addr_q, cache_addr_d;
    logic [47:0]   buf_q, buf_d;
    logic [2:0]    n_q, n_d;
    logic          tx_started_q, tx_started_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [3:0]    tx_tick_q, tx_tick_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_sync_q, rx_sync_d;
    logic          rx_last_q, rx_last_d;
    logic          rx_busy_q, rx_busy_d;
    logic [7:0]    rx_cnt_q, rx_cnt_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_cnt_inc;
    logic          rx_good;
    logic          send_m;

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        tx_d          = tx_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        buf_d         = buf_q;
        n_d           = n_q;
        tx_started_d  = tx_started_q;
        tx_bit_d      = tx_bit_q;
        tx_tick_d     = tx_tick_q;
        to_cnt_d      = to_cnt_q;
        rx_meta_d     = uart_rx;
        rx_sync_d     = rx_meta_q;
        rx_last_d     = rx_last_q;
        rx_busy_d     = rx_busy_q;
        rx_cnt_d      = rx_cnt_q;
        rx_shift_d    = rx_shift_q;
        rx_cnt_inc    = rx_cnt_q + 8'd1;
        rx_good       = 1'b0;
        send_m        = !((ADDR_CACHE != 0) && cache_valid_q && (addr_q == cache_addr_q));

        // Receiver runs continuously; rx_cnt counts ticks since the start edge.
        if (baudclk16) begin
            rx_last_d = rx_sync_q;
            if (!rx_busy_q) begin
                if (rx_last_q && !rx_sync_q) begin
                    rx_busy_d = 1'b1;
                    rx_cnt_d  = 8'd0;
                end
            end else begin
                rx_cnt_d = rx_cnt_inc;
                if (rx_cnt_inc == 8'd8) begin
                    if (rx_sync_q) rx_busy_d = 1'b0;
                end else if (rx_cnt_inc == 8'd152) begin
                    rx_busy_d = 1'b0;
                    rx_good   = rx_sync_q;
                end else if (rx_cnt_inc[3:0] == 4'd8) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    wr_d        = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                // First character to send sits in the low byte of buf.
                if (wr_q) begin
                    if (send_m) begin
                        buf_d = {8'h77, 4'h3, wdata_q[3:0], 4'h3, wdata_q[7:4],
                                 8'h6D, 4'h3, addr_q[3:0], 4'h3, addr_q[7:4]};
                        n_d   = 3'd6;
                    end else begin
                        buf_d = {24'h0, 8'h77, 4'h3, wdata_q[3:0], 4'h3, wdata_q[7:4]};
                        n_d   = 3'd3;
                    end
                end else if (send_m) begin
                    buf_d = {16'h0, 8'h72, 8'h6D, 4'h3, addr_q[3:0], 4'h3, addr_q[7:4]};
                    n_d   = 3'd4;
                end else begin
                    buf_d = {40'h0, 8'h72};
                    n_d   = 3'd1;
                end
                if (send_m) begin
                    cache_valid_d = 1'b1;
                    cache_addr_d  = addr_q;
                end
                tx_started_d = 1'b0;
                state_d      = S_SEND;
            end
            S_SEND: begin
                if (baudclk16) begin
                    if (!tx_started_q) begin
                        tx_started_d = 1'b1;
                        tx_d         = 1'b0;
                        tx_bit_d     = 4'd0;
                        tx_tick_d    = 4'd0;
                    end else if (tx_tick_q == 4'd15) begin
                        tx_tick_d = 4'd0;
                        if (tx_bit_q == 4'd9) begin
                            if (n_q == 3'd1) begin
                                tx_d         = 1'b1;
                                tx_started_d = 1'b0;
                                if (wr_q) begin
                                    state_d       = S_RESP;
                                    rsp_valid_d   = 1'b1;
                                    rsp_rdata_d   = 8'h00;
                                    rsp_timeout_d = 1'b0;
                                end else begin
                                    state_d  = S_WAIT_RX;
                                    to_cnt_d = '0;
                                end
                            end else begin
                                buf_d    = {8'h00, buf_q[47:8]};
                                n_d      = n_q - 3'd1;
                                tx_bit_d = 4'd0;
                                tx_d     = 1'b0;
                            end
                        end else begin
                            tx_bit_d = tx_bit_q + 4'd1;
                            tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : buf_q[tx_bit_q[2:0]];
                        end
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
            S_WAIT_RX: begin
                // A completed good byte wins over a timeout on the same tick.
                if (rx_good) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = rx_shift_q;
                    rsp_timeout_d = 1'b0;
                end else if (baudclk16) begin
                    if (to_cnt_q == TO_LAST) begin
                        state_d       = S_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = 8'hFF;
                        rsp_timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
            tx_q          <= 1'b1;
            wr_q          <= 1'b0;
            addr_q        <= 8'h00;
            wdata_q       <= 8'h00;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= 8'h00;
            buf_q         <= 48'h0;
            n_q           <= 3'd0;
            tx_started_q  <= 1'b0;
            tx_bit_q      <= 4'd0;
            tx_tick_q     <= 4'd0;
            to_cnt_q      <= '0;
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_last_q     <= 1'b1;
            rx_busy_q     <= 1'b0;
            rx_cnt_q      <= 8'd0;
            rx_shift_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            tx_q          <= tx_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            buf_q         <= buf_d;
            n_q           <= n_d;
            tx_started_q  <= tx_started_d;
            tx_bit_q      <= tx_bit_d;
            tx_tick_q     <= tx_tick_d;
            to_cnt_q      <= to_cnt_d;
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            rx_last_q     <= rx_last_d;
            rx_busy_q     <= rx_busy_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_shift_q    <= rx_shift_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign uart_tx     = tx_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: one instance with the address cache, one without,
// a serial line decoder on the selected uart_tx and a response capture queue.
module tb_uart_cmd_master;
    localparam int TO = 400;

    typedef struct {
        bit               sel;
        bit               wr;
        logic [7:0]       addr;
        logic [7:0]       wdata;
        int               mode;   // 0 no reply, 1 good reply, 2 bad-stop then good
        logic [7:0]       rep1;
        logic [7:0]       rep2;
        int               n;
        logic [0:5][7:0]  ch;
        logic [7:0]       rdata;
        bit               to;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] baud_cnt = 2'd0;
    logic       baud;
    int         tick_no = 0;

    logic       req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
    logic       rx = 1'b1;
    logic       req_ready_a, rsp_valid_a, rsp_timeout_a, tx_a;
    logic       req_ready_b, rsp_valid_b, rsp_timeout_b, tx_b;
    logic [7:0] rsp_rdata_a, rsp_rdata_b;
    logic [2:0] dbg_a, dbg_b;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    assign baud = (baud_cnt == 2'd3);
    always @(posedge clk) begin
        baud_cnt <= baud_cnt + 2'd1;
        if (baud) tick_no <= tick_no + 1;
    end

    uart_cmd_master #(.ADDR_CACHE(1), .RX_TIMEOUT(TO)) dut_a (
        .clk(clk), .reset_n(reset_n), .baudclk16(baud),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_timeout(rsp_timeout_a),
        .uart_tx(tx_a), .uart_rx(rx), .dbg_state(dbg_a)
    );

    uart_cmd_master #(.ADDR_CACHE(0), .RX_TIMEOUT(TO)) dut_b (
        .clk(clk), .reset_n(reset_n), .baudclk16(baud),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_timeout(rsp_timeout_b),
        .uart_tx(tx_b), .uart_rx(rx), .dbg_state(dbg_b)
    );

    // Serial decoder on the selected transmitter
    bit         mon_sel = 1'b0;
    bit         mon_busy = 1'b0;
    bit         mon_prev = 1'b1;
    bit         mon_bad = 1'b0;
    int         mon_t0 = 0;
    int         mon_k = 0;
    logic [7:0] mon_sh = 8'h00;
    logic [7:0] got_q[$];
    int         got_t0_q[$];
    bit         got_ok_q[$];

    always @(negedge clk) begin
        logic t;
        t = mon_sel ? tx_b : tx_a;
        if (!reset_n) begin
            mon_busy = 1'b0;
            mon_prev = 1'b1;
        end else begin
            if (!mon_busy) begin
                if (!t) begin
                    mon_busy = 1'b1;
                    mon_t0   = tick_no;
                    mon_k    = 0;
                    mon_bad  = 1'b0;
                end
            end else begin
                if (t != mon_prev && ((tick_no - mon_t0) % 16) != 0) mon_bad = 1'b1;
                if (tick_no == mon_t0 + 8 + 16 * mon_k) begin
                    if (mon_k == 0) begin
                        if (t) mon_bad = 1'b1;
                    end else if (mon_k <= 8) begin
                        mon_sh = {t, mon_sh[7:1]};
                    end else begin
                        if (!t) mon_bad = 1'b1;
                        got_q.push_back(mon_sh);
                        got_t0_q.push_back(mon_t0);
                        got_ok_q.push_back(!mon_bad);
                        mon_busy = 1'b0;
                    end
                    mon_k++;
                end
            end
            mon_prev = t;
        end
    end

    // Response capture
    logic [7:0] rsp_data_q[$];
    bit         rsp_to_q[$];
    int         rsp_tick_q[$];

    always @(negedge clk) begin
        if (reset_n && (mon_sel ? rsp_valid_b : rsp_valid_a)) begin
            rsp_data_q.push_back(mon_sel ? rsp_rdata_b : rsp_rdata_a);
            rsp_to_q.push_back(mon_sel ? rsp_timeout_b : rsp_timeout_a);
            rsp_tick_q.push_back(tick_no);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = tick_no + n;
        while (tick_no < target) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input bit stop);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        rx = stop;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(20);
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int g;
        g = 0;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        if (v.sel) req_valid_b = 1'b1;
        else       req_valid_a = 1'b1;
        while (!(v.sel ? req_ready_b : req_ready_a) && g < 2000) begin
            step();
            g++;
        end
        check({tag, "_ready"}, v.sel ? req_ready_b : req_ready_a, 1);
        step();
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic clear_queues();
        got_q.delete();
        got_t0_q.delete();
        got_ok_q.delete();
        rsp_data_q.delete();
        rsp_to_q.delete();
        rsp_tick_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int g;
        int last_end;
        clear_queues();
        mon_sel = v.sel;
        do_req(v, tag);
        if (v.mode != 0) begin
            g = 0;
            while (got_q.size() < v.n && g < 2000) begin
                wait_ticks(1);
                g++;
            end
            wait_ticks(20);
            send_rx(v.rep1, v.mode == 1);
            if (v.mode == 2) send_rx(v.rep2, 1'b1);
        end
        g = 0;
        while (rsp_data_q.size() == 0 && g < 3000) begin
            wait_ticks(1);
            g++;
        end
        wait_ticks(20);
        check({tag, "_nchars"}, got_q.size(), v.n);
        for (int i = 0; i < v.n && i < got_q.size(); i++) begin
            check($sformatf("%s_char%0d", tag, i), got_q[i], v.ch[i]);
            check($sformatf("%s_bittime%0d", tag, i), got_ok_q[i], 1);
            if (i > 0) check($sformatf("%s_gap%0d", tag, i), got_t0_q[i] - got_t0_q[i-1], 160);
        end
        check({tag, "_rsp_count"}, rsp_data_q.size(), 1);
        if (rsp_data_q.size() > 0) begin
            check({tag, "_rdata"}, rsp_data_q[0], v.rdata);
            check({tag, "_timeout"}, rsp_to_q[0], v.to);
            if (got_q.size() > 0) begin
                last_end = got_t0_q[got_q.size()-1] + 160;
                if (v.wr) check({tag, "_wr_rsp_tick"}, rsp_tick_q[0] - last_end, 0);
                if (v.to) check({tag, "_to_rsp_tick"}, rsp_tick_q[0] - last_end, TO);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        vecs[0] = '{0, 1, 8'h11, 8'hA5, 0, 8'h00, 8'h00, 6, 48'h31316D3A3577, 8'h00, 0};
        vecs[1] = '{0, 0, 8'h11, 8'h00, 1, 8'h5C, 8'h00, 1, 48'h720000000000, 8'h5C, 0};
        vecs[2] = '{0, 0, 8'h20, 8'h00, 0, 8'h00, 8'h00, 4, 48'h32306D720000, 8'hFF, 1};
        vecs[3] = '{0, 0, 8'h20, 8'h00, 2, 8'h3C, 8'h7E, 1, 48'h720000000000, 8'h7E, 0};
        vecs[4] = '{1, 1, 8'h5A, 8'h01, 0, 8'h00, 8'h00, 6, 48'h353A6D303177, 8'h00, 0};
        vecs[5] = '{1, 1, 8'h5A, 8'hF0, 0, 8'h00, 8'h00, 6, 48'h353A6D3F3077, 8'h00, 0};

        // Power-on reset
        reset_n = 1'b0;
        repeat (4) step();
        check("rst_tx", tx_a, 1);
        check("rst_ready", req_ready_a, 0);
        check("rst_rsp_valid", rsp_valid_a, 0);
        check("rst_rdata", rsp_rdata_a, 8'h00);
        check("rst_timeout", rsp_timeout_a, 0);
        check("rst_state_a", dbg_a, 0);
        check("rst_state_b", dbg_b, 0);
        reset_n = 1'b1;
        step();
        check("post_rst_ready_a", req_ready_a, 1);
        check("post_rst_ready_b", req_ready_b, 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Glitch and an unsolicited byte while idle must not produce a response
        clear_queues();
        mon_sel = 1'b0;
        rx = 1'b0;
        wait_ticks(1);
        rx = 1'b1;
        wait_ticks(40);
        send_rx(8'h55, 1'b1);
        wait_ticks(40);
        check("idle_rx_no_rsp", rsp_data_q.size(), 0);
        check("idle_rx_ready", req_ready_a, 1);
        v = '{0, 0, 8'h20, 8'h00, 1, 8'h42, 8'h00, 1, 48'h720000000000, 8'h42, 0};
        run_vec(v, "post_glitch");

        // Reset in the middle of the 'm' character
        clear_queues();
        v = '{0, 0, 8'h44, 8'h00, 1, 8'h99, 8'h00, 4, 48'h34346D720000, 8'h99, 0};
        do_req(v, "midrst");
        for (int g = 0; g < 2000 && got_q.size() < 2; g++) wait_ticks(1);
        wait_ticks(40);
        reset_n = 1'b0;
        step();
        check("midrst_tx", tx_a, 1);
        check("midrst_ready", req_ready_a, 0);
        check("midrst_rdata", rsp_rdata_a, 8'h00);
        check("midrst_rsp_valid", rsp_valid_a, 0);
        reset_n = 1'b1;
        step();
        check("midrst_ready_after", req_ready_a, 1);
        run_vec(v, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
